nios_system_sysid_ext: RTL
==========================

// Module: nios_system_sysid_ext
// PURPOSE
//  Parametrised system-ID/info slave on the Nios II Avalon-MM fabric. Returns build
//  constants (ID, timestamp, version) plus a scratch register and a prescaled 64-bit
//  uptime counter with coherent hi/lo snapshot, sticky overflow flag and control bits.
//  Fixed read latency (readdatavalid), no waitrequest; lets software identify the image
//  and timestamp events without a dedicated timer core.
// PARAMETERS
//  SYSTEM_ID     32'h0000_0000  value at word 0
//  TIMESTAMP     32'd1346454749 build time (epoch s), word 1
//  VERSION       32'h0001_0000  major[31:16]/minor[15:0], word 2
//  PRESCALE      1              clocks per uptime tick, 1..65535
//  READ_LATENCY  1              cycles read -> readdatavalid, legal 1 or 2
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  address        in   3   word address
//  read           in   1   read strobe, one cycle per access
//  write          in   1   write strobe, one cycle per access
//  writedata      in   32  write data
//  byteenable     in   4   byte lanes for writes
//  readdata       out  32  read data, valid when readdatavalid=1
//  readdatavalid  out  1   read response strobe
// BEHAVIOUR
//  Reset: readdata=0, readdatavalid=0, SCRATCH=0, uptime=0, shadow=0, ENABLE=1,
//   OVF=0, prescale count=0. Async assert, sync deassert handled upstream.
//  Map: 0 SYSTEM_ID RO | 1 TIMESTAMP RO | 2 VERSION RO | 3 SCRATCH RW (byteenable)
//   4 UPTIME_LO RO, read copies uptime[63:32] into shadow same cycle | 5 UPTIME_HI
//   RO, returns shadow | 6 CONTROL: bit0 ENABLE RW, bit1 CLEAR W1 self-clearing
//   (reads 0) | 7 STATUS: bit0 OVF sticky, write 1 to clear. Unused bits read 0.
//  Writes to RO words ignored. Writes take effect next edge.
//  Read: sample address on read cycle; data registered, readdatavalid pulses exactly
//   READ_LATENCY cycles later; back-to-back reads give back-to-back responses.
//  Read+write same cycle (same addr): read returns pre-write value, write applied.
//  Uptime: prescale counter counts 0..PRESCALE-1 when ENABLE; tick on terminal count
//   increments uptime. ENABLE=0 freezes both counters (no reset of prescale).
//  Snapshot coherence: LO read captures {hi,lo} of same pre-increment value even if a
//   tick lands that cycle.
//  Wrap: tick at 64'hFFFF_FFFF_FFFF_FFFF -> 0 and OVF<=1. OVF set beats W1C same cycle.
//  CLEAR write: uptime and prescale <=0 next edge; CLEAR beats a simultaneous tick;
//   shadow untouched.
//  Reset mid-read: pending readdatavalid dropped, no response issued after reset.
// STRUCTURE
//  Package nios_sysid_pkg: register offsets (REG_SYSID..REG_STATUS), CONTROL/STATUS
//   bit indices, ADDR_W=3, DATA_W=32.
//  Sub-module sysid_uptime_counter: prescaler + 64-bit counter, inputs enable/clear,
//   outputs count[63:0], wrap pulse. Top holds decode, registers, read pipeline.
// TESTING
//  Reset, read words 0..2 -> params exactly (word1=1346454749), readdatavalid at +L.
//  Write SCRATCH 32'hDEADBEEF be=4'b0101 over 0 -> read 32'h00AD00EF.
//  PRESCALE=4, 40 clocks enabled -> uptime 10; ENABLE=0 for 20 clocks -> still 10.
//  Force uptime 64'h0000_0001_FFFF_FFFF, read LO on tick cycle -> LO=FFFF_FFFF,
//   then HI=0000_0001 (not 2).
//  Preload all-ones, one tick -> uptime 0, STATUS=1; write STATUS 1 -> 0; set+W1C
//   same cycle -> 1.
//  CLEAR on tick cycle -> uptime 0; assert reset_n=0 one cycle after read -> no
//   readdatavalid.

Source files
------------

// File: rtl/nios_sysid_pkg.sv
// Shared constants for the system-ID/uptime slave: word map, register bit
// positions, read pipeline slot type and the byte-lane merge helper.
package nios_sysid_pkg;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic [ADDR_W-1:0] {
      REG_SYSID     = 3'd0,
      REG_TIMESTAMP = 3'd1,
      REG_VERSION   = 3'd2,
      REG_SCRATCH   = 3'd3,
      REG_UPTIME_LO = 3'd4,
      REG_UPTIME_HI = 3'd5,
      REG_CONTROL   = 3'd6,
      REG_STATUS    = 3'd7
   } reg_addr_e;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_CLEAR_BIT  = 1;
   localparam int STAT_OVF_BIT    = 0;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } rd_slot_t;

   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_val,
      input logic [DATA_W-1:0] new_val,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus for the system-ID block: fixed-latency reads with
// readdatavalid, no waitrequest.
interface nios_system_sysid_ext_if;
   import nios_sysid_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, readdatavalid
   );

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, readdatavalid
   );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Prescaled 64-bit uptime counter: one count per PRESCALE enabled clocks,
// synchronous clear, and a wrap pulse when the count rolls over to zero.
module sysid_uptime_counter #(
   parameter int PRESCALE = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        clear,
   output logic [63:0] count,
   output logic        wrap
);

   localparam logic [15:0] TERM = 16'(PRESCALE - 1);

   logic [15:0] presc_q, presc_d;
   logic [63:0] count_q, count_d;
   logic        tick;

   // Clear wins over a tick landing in the same cycle, and suppresses its wrap.
   always_comb begin
      tick    = enable && (presc_q == TERM);
      presc_d = presc_q;
      count_d = count_q;
      wrap    = 1'b0;
      if (clear) begin
         presc_d = '0;
         count_d = '0;
      end else if (tick) begin
         presc_d = '0;
         count_d = count_q + 64'd1;
         wrap    = &count_q;
      end else if (enable) begin
         presc_d = presc_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         count_q <= '0;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/nios_system_sysid_ext.sv
// System-ID / info slave: build constants, scratch word, uptime counter with a
// coherent hi/lo snapshot, sticky overflow flag and a fixed-latency read path.
module nios_system_sysid_ext
   import nios_sysid_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP    = 32'd1346454749,
   parameter logic [31:0] VERSION      = 32'h0001_0000,
   parameter int          PRESCALE     = 1,
   parameter int          READ_LATENCY = 1
) (
   input logic                    clock,
   input logic                    reset_n,
   nios_system_sysid_ext_if.slave avs
);

   logic [DATA_W-1:0] scratch_q, scratch_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic              enable_q, enable_d;
   logic              ovf_q, ovf_d;

   rd_slot_t [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;

   logic [63:0]       uptime;
   logic              wrap;
   logic              clear;
   logic              wr_scratch, wr_control, wr_status, rd_lo;
   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      wr_scratch = avs.write && (avs.address == REG_SCRATCH);
      wr_control = avs.write && (avs.address == REG_CONTROL);
      wr_status  = avs.write && (avs.address == REG_STATUS);
      rd_lo      = avs.read  && (avs.address == REG_UPTIME_LO);
      clear      = wr_control && avs.writedata[CTRL_CLEAR_BIT];
   end

   sysid_uptime_counter #(
      .PRESCALE (PRESCALE)
   ) u_uptime (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable_q),
      .clear   (clear),
      .count   (uptime),
      .wrap    (wrap)
   );

   // A counter wrap re-arms OVF even when software clears it in the same cycle.
   always_comb begin
      scratch_d = scratch_q;
      if (wr_scratch) scratch_d = merge_bytes(scratch_q, avs.writedata, avs.byteenable);
      enable_d = enable_q;
      if (wr_control) enable_d = avs.writedata[CTRL_ENABLE_BIT];
      ovf_d = ovf_q;
      if (wrap) ovf_d = 1'b1;
      else if (wr_status && avs.writedata[STAT_OVF_BIT]) ovf_d = 1'b0;
      shadow_d = shadow_q;
      if (rd_lo) shadow_d = uptime[63:32];
   end

   // Reads see pre-write register state; LO and the shadowed HI come from the same count.
   always_comb begin
      rd_mux = '0;
      case (reg_addr_e'(avs.address))
         REG_SYSID:     rd_mux = SYSTEM_ID;
         REG_TIMESTAMP: rd_mux = TIMESTAMP;
         REG_VERSION:   rd_mux = VERSION;
         REG_SCRATCH:   rd_mux = scratch_q;
         REG_UPTIME_LO: rd_mux = uptime[31:0];
         REG_UPTIME_HI: rd_mux = shadow_q;
         REG_CONTROL:   rd_mux = {{(DATA_W-1){1'b0}}, enable_q};
         REG_STATUS:    rd_mux = {{(DATA_W-1){1'b0}}, ovf_q};
         default:       rd_mux = '0;
      endcase
   end

   always_comb begin
      rd_pipe_d          = rd_pipe_q;
      rd_pipe_d[0].valid = avs.read;
      rd_pipe_d[0].data  = avs.read ? rd_mux : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q <= '0;
         shadow_q  <= '0;
         enable_q  <= 1'b1;
         ovf_q     <= 1'b0;
         rd_pipe_q <= '0;
      end else begin
         scratch_q <= scratch_d;
         shadow_q  <= shadow_d;
         enable_q  <= enable_d;
         ovf_q     <= ovf_d;
         rd_pipe_q <= rd_pipe_d;
      end
   end

   assign avs.readdata      = rd_pipe_q[READ_LATENCY-1].data;
   assign avs.readdatavalid = rd_pipe_q[READ_LATENCY-1].valid;

endmodule
